// File: rtl/sm_accum.sv
// Streaming sign-magnitude accumulator.
// Folds a sequence of sign-magnitude partial sums into one saturated
// sign-magnitude result, presented on a valid/ready output.
// Terms are summed in widened two's complement (N+G bits). That width
// cannot overflow within MAX_TERMS terms, so saturation only happens once,
// when the final sum is converted back to sign-magnitude.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting terms, in_ready=1, no result pending
// DONE  | result held on out_data/out_sat, out_valid=1, inputs ignored
module sm_accum #(
   parameter int Q         = 15,
   parameter int N         = 32,
   parameter int MAX_TERMS = 16,
   parameter int G         = $clog2(MAX_TERMS)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_sat
);

   localparam int W = N + G;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t         state_q;
   logic [W-1:0]   acc_q;
   logic [W-1:0]   acc_d;
   logic [G-1:0]   count_q;
   logic [G-1:0]   count_d;
   logic           in_ready_q;
   logic           out_valid_q;
   logic [N-1:0]   out_data_q;
   logic           out_sat_q;

   logic [W-1:0]   mag_ext;
   logic [W-1:0]   term;
   logic [W-1:0]   final_abs;
   logic           last_beat;
   logic           ovf;
   logic [N-1:0]   result_d;

   // The fractional position does not affect the arithmetic; this only
   // ties off the format parameter.
   logic           unused_fmt;
   assign unused_fmt = (Q < N);

   // Term conversion, running sum and sign-magnitude conversion of the
   // sum that would result if this beat were the last one.
   always_comb begin
      mag_ext   = {{(G+1){1'b0}}, in_data[N-2:0]};
      // Negative zero negates to zero, so it needs no special case.
      term      = in_data[N-1] ? ('0 - mag_ext) : mag_ext;
      acc_d     = acc_q + term;
      count_d   = count_q + G'(1);
      last_beat = in_last | (count_q == G'(MAX_TERMS-1));
      final_abs = acc_d[W-1] ? ('0 - acc_d) : acc_d;
      ovf       = |final_abs[W-1:N-1];
      // A zero sum is non-negative in two's complement, so it always
      // comes out as +0.
      result_d  = {acc_d[W-1], ovf ? {(N-1){1'b1}} : final_abs[N-2:0]};
   end

   // Sequencing FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (clear) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  if (last_beat) begin
                     acc_q       <= '0;
                     count_q     <= '0;
                     out_data_q  <= result_d;
                     out_sat_q   <= ovf;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state_q     <= DONE;
                  end else begin
                     acc_q   <= acc_d;
                     count_q <= count_d;
                  end
               end
            end
            DONE: begin
               // No bypass: the next term is taken on the cycle after release.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ACCUM;
               end
            end
            default: begin
               state_q    <= ACCUM;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: doc/sm_accum.md
Name: sm_accum

Overview:
- Streaming accumulator that sits directly downstream of the fixed-point sign-magnitude adder stage in the neuron datapath.
- Consumes a sequence of partial sums in the same N-bit sign-magnitude Q format (bit N-1 = sign, bits N-2:0 = magnitude, Q fractional bits).
- Reduces each sequence to one saturated neuron sum and presents it on a valid/ready output for the activation/writeback stage.
- Avoids the wrap-around of the combinational adder by accumulating internally in widened two's complement.

Parameters:
- Q, 15, fractional bits of data format (informational; arithmetic is format-agnostic).
- N, 32, data width including sign bit.
- MAX_TERMS, 16, maximum terms per sequence (power of two, >= 2).
- G, clog2(MAX_TERMS), guard bits of internal accumulator.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of in-progress sequence and any pending result.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block accepts a term this cycle.
- in_data  input  N  sign-magnitude partial sum.
- in_last  input  1  marks final term of sequence.
- out_valid  output  1  out_data holds a completed sum.
- out_ready  input  1  downstream accepts result.
- out_data  output  N  sign-magnitude saturated sum.
- out_sat  output  1  result was clamped; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM, acc=0, count=0, out_valid=0, out_data=0, out_sat=0.
  - in_ready=1 immediately when reset deasserts.
- Internal accumulator: N+G bits two's complement.
  - Each accepted term is converted as +mag or -mag; 0x80..0 (negative zero) converts to 0.
  - No internal overflow is possible within MAX_TERMS terms.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- ACCUM, on beat (in_valid & in_ready):
  - acc <= acc + term; count <= count+1.
  - If in_last=1 or count==MAX_TERMS-1: final = acc+term; load out_data/out_sat from final; acc<=0; count<=0; go DONE.
- Output conversion:
  - |final| > 2^(N-1)-1 → magnitude clamps to all ones, sign preserved, out_sat=1.
  - Otherwise magnitude = |final|, out_sat=0.
  - final==0 always produces 0x0 (sign bit 0).
- Latency: out_valid rises the cycle after the final beat is accepted.
- DONE:
  - out_data and out_sat held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid<=0, go ACCUM. The next term is accepted no earlier than the following cycle (no same-cycle bypass).
- Inputs presented while in DONE are ignored; upstream must hold them.
- clear=1:
  - Next edge forces state=ACCUM, acc=0, count=0, out_valid=0, out_sat=0.
  - Overrides any concurrent beat or output handshake.
  - Any beat presented in the clear cycle is dropped.
- Single-term sequence (in_last on first beat): result = converted term, including normalisation of negative zero.
- Throughput: one result per (terms+1) cycles minimum.

Test Plan:
- Reset with in_valid=1 held → out_valid=0, out_data=0 during reset; in_ready=1 the first cycle after rst_n rises.
- Terms 0x00008000 (1.0), 0x00010000 (2.0), 0x80004000 (-0.5, in_last), out_ready=1 → one cycle later out_valid=1, out_data=0x00014000, out_sat=0; returns to ACCUM next cycle.
- Terms 0x00008000, 0x80008000 (last) → out_data=0x00000000. Single term 0x80000000 (last) → out_data=0x00000000.
- Positive overflow, 0x7FFFFFFF + 0x00000001 (last) → out_data=0x7FFFFFFF, out_sat=1. Negative overflow, 0xFFFFFFFF + 0x80000001 (last) → out_data=0xFFFFFFFF, out_sat=1.
- Backpressure: result 2.5 pending with out_ready=0 for 3 cycles while in_valid=1 → out_data stable, in_ready=0, nothing accepted; out_ready=1 → next sequence's first term accepted the following cycle.
- MAX_TERMS/clear:
  - 16 beats of 0x00008000 with no in_last → out_data=0x00080000 after the 16th beat.
  - Separately, 2 beats then clear=1 → out_valid stays 0, and the next sequence 0x00008000 (last) yields 0x00008000.
